// File: rtl/stp_decoder_if.sv
// Step/direction receiver bus: stimulus from the driver side, position,
// read handshake and status back from the decoder.
interface stp_decoder_if;
  logic       step_i;
  logic       dir_i;
  logic       clr_i;
  logic       rd_req_i;
  logic [7:0] pos_o;
  logic [7:0] rd_pos_o;
  logic       rd_ack_o;
  logic       moving_o;
  logic       done_o;
  logic       err_o;
  logic [2:0] err_code_o;

  modport master (
    output step_i, dir_i, clr_i, rd_req_i,
    input  pos_o, rd_pos_o, rd_ack_o, moving_o, done_o, err_o, err_code_o
  );

  modport slave (
    input  step_i, dir_i, clr_i, rd_req_i,
    output pos_o, rd_pos_o, rd_ack_o, moving_o, done_o, err_o, err_code_o
  );
endinterface

// File: rtl/stp_decoder.sv
// Step/direction decoder: counts rising step edges into an absolute position
// clamped to 0..MAX_POS, flags overrange / step-rate / direction-setup errors
// (sticky, clearable), tracks motion with an idle timeout and serves a
// 4-phase position snapshot handshake. All outputs come straight from flops.
module stp_decoder #(
  parameter int MAX_POS   = 240,
  parameter int MIN_PER   = 2,
  parameter int DIR_SETUP = 1,
  parameter int IDLE_CYC  = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  stp_decoder_if.slave bus
);

  localparam logic [7:0] MAX_POS_C   = 8'(MAX_POS);
  localparam logic [7:0] MIN_PER_C   = 8'(MIN_PER);
  localparam logic [7:0] DIR_SETUP_C = 8'(DIR_SETUP);
  localparam logic [7:0] IDLE_LAST_C = 8'(IDLE_CYC - 1);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_MOVING = 1'b1
  } motion_e;

  motion_e    state_r, state_nxt_s;
  logic       step_q_r, dir_q_r, first_step_r;
  logic [7:0] per_cnt_r, per_cnt_nxt_s;
  logic [7:0] dst_cnt_r, dst_cnt_nxt_s;
  logic [7:0] idle_cnt_r, idle_cnt_nxt_s;
  logic [7:0] pos_r, pos_nxt_s;
  logic [7:0] rd_pos_r, rd_pos_nxt_s;
  logic       rd_ack_r, rd_ack_nxt_s;
  logic       done_r, done_nxt_s;
  logic [2:0] err_r, err_nxt_s, err_new_s;
  logic       err_any_r;
  logic       rise_s;

  // Inputs are already clk_i-synchronous, so one flop is enough for edges.
  assign rise_s = bus.step_i & ~step_q_r;

  assign bus.pos_o      = pos_r;
  assign bus.rd_pos_o   = rd_pos_r;
  assign bus.rd_ack_o   = rd_ack_r;
  assign bus.moving_o   = (state_r == ST_MOVING);
  assign bus.done_o     = done_r;
  assign bus.err_o      = err_any_r;
  assign bus.err_code_o = err_r;

  // Position update, period / dir-stable counters and sticky error merge.
  always_comb begin
    pos_nxt_s     = pos_r;
    per_cnt_nxt_s = per_cnt_r;
    dst_cnt_nxt_s = dst_cnt_r;
    err_new_s     = 3'b000;
    err_nxt_s     = err_r;

    // Counts cycles dir_i has been stable including the current one, so a
    // change in the same cycle as an edge reads as zero setup.
    if (bus.dir_i != dir_q_r) begin
      dst_cnt_nxt_s = 8'd0;
    end else if (dst_cnt_r != 8'hFF) begin
      dst_cnt_nxt_s = dst_cnt_r + 8'd1;
    end else begin
      dst_cnt_nxt_s = dst_cnt_r;
    end

    if (rise_s) begin
      per_cnt_nxt_s = 8'd1;
      if (bus.dir_i == 1'b0) begin
        if (pos_r == MAX_POS_C) begin
          err_new_s[0] = 1'b1;
        end else begin
          pos_nxt_s = pos_r + 8'd1;
        end
      end else begin
        if (pos_r == 8'd0) begin
          err_new_s[0] = 1'b1;
        end else begin
          pos_nxt_s = pos_r - 8'd1;
        end
      end
      // The very first edge after reset has no predecessor to be timed against.
      if (!first_step_r && (per_cnt_r < MIN_PER_C)) begin
        err_new_s[1] = 1'b1;
      end else begin
        err_new_s[1] = 1'b0;
      end
      if (dst_cnt_nxt_s < DIR_SETUP_C) begin
        err_new_s[2] = 1'b1;
      end else begin
        err_new_s[2] = 1'b0;
      end
    end else if (per_cnt_r != 8'hFF) begin
      per_cnt_nxt_s = per_cnt_r + 8'd1;
    end else begin
      per_cnt_nxt_s = per_cnt_r;
    end

    // A new error in the clearing cycle survives the clear.
    if (bus.clr_i) begin
      err_nxt_s = err_new_s;
    end else begin
      err_nxt_s = err_r | err_new_s;
    end
  end

  // Motion FSM: any edge (re)starts motion, idle timeout ends it with done.
  always_comb begin
    state_nxt_s    = state_r;
    idle_cnt_nxt_s = idle_cnt_r;
    done_nxt_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (rise_s) begin
          state_nxt_s    = ST_MOVING;
          idle_cnt_nxt_s = 8'd0;
        end else begin
          idle_cnt_nxt_s = 8'd0;
        end
      end
      ST_MOVING: begin
        if (rise_s) begin
          idle_cnt_nxt_s = 8'd0;
        end else if (idle_cnt_r == IDLE_LAST_C) begin
          state_nxt_s    = ST_IDLE;
          idle_cnt_nxt_s = 8'd0;
          done_nxt_s     = 1'b1;
        end else begin
          idle_cnt_nxt_s = idle_cnt_r + 8'd1;
        end
      end
      default: begin
        state_nxt_s    = ST_IDLE;
        idle_cnt_nxt_s = 8'd0;
      end
    endcase
  end

  // 4-phase read: snapshot the pre-step position once per request.
  always_comb begin
    rd_pos_nxt_s = rd_pos_r;
    rd_ack_nxt_s = rd_ack_r;
    if (bus.rd_req_i && !rd_ack_r) begin
      rd_pos_nxt_s = pos_r;
      rd_ack_nxt_s = 1'b1;
    end else if (!bus.rd_req_i) begin
      rd_ack_nxt_s = 1'b0;
    end else begin
      rd_ack_nxt_s = rd_ack_r;
    end
  end

  // State register for all decoder state; reset discards motion silently.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r      <= ST_IDLE;
      step_q_r     <= 1'b0;
      dir_q_r      <= 1'b0;
      first_step_r <= 1'b1;
      per_cnt_r    <= 8'd0;
      dst_cnt_r    <= 8'd0;
      idle_cnt_r   <= 8'd0;
      pos_r        <= 8'd0;
      rd_pos_r     <= 8'd0;
      rd_ack_r     <= 1'b0;
      done_r       <= 1'b0;
      err_r        <= 3'b000;
      err_any_r    <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      step_q_r     <= bus.step_i;
      dir_q_r      <= bus.dir_i;
      first_step_r <= first_step_r & ~rise_s;
      per_cnt_r    <= per_cnt_nxt_s;
      dst_cnt_r    <= dst_cnt_nxt_s;
      idle_cnt_r   <= idle_cnt_nxt_s;
      pos_r        <= pos_nxt_s;
      rd_pos_r     <= rd_pos_nxt_s;
      rd_ack_r     <= rd_ack_nxt_s;
      done_r       <= done_nxt_s;
      err_r        <= err_nxt_s;
      err_any_r    <= |err_nxt_s;
    end
  end

endmodule
